prbs_checker: RTL
=================

Name: prbs_checker

Overview:
- Receive-side counterpart of the 6-bit LFSR pattern generator.
- Takes the serial PRBS bit stream (generator MSB tap, x^6+x^5+1, period 63), self-synchronises to it, and counts bit errors.
- Sits at the far end of a loopback or board link, with the generator's slow tick on the link presented as a one-cycle rx_valid strobe in the checker's clock domain.

Parameters:
- LOCK_CNT, 8: consecutive correct predictions required before declaring lock.
- WIN_LEN, 63: length in valid bits of the loss-of-lock observation window.
- LOSS_THRESH, 4: errors within one window that force loss of lock.
- ERR_W, 16: width of the error counter.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe; rx_bit is sampled when high.
- rx_bit  in  1  received PRBS bit.
- clr  in  1  synchronous clear of statistics counters.
- locked  out  1  checker is synchronised and checking.
- err_pulse  out  1  one-cycle pulse per detected bit error.
- err_cnt  out  ERR_W  saturating count of errors detected while locked.

Interface decision: one clock; reset is synchronous and active-high; ports named clk and rst.

Behaviour:
- Bit recurrence: b(t) = b(t-5) XOR b(t-6).
- History register hist[5:0] shifts left on each rx_valid; the new bit enters at hist[0].
- Prediction pred = hist[4] XOR hist[5]. Mismatch means rx_bit != pred.
- Cycles with rx_valid=0 change no state; all inputs are ignored except rst and clr.
- FSM state ACQ (fill):
  - Shift rx_bit into hist; fill_cnt counts 0..6.
  - When fill_cnt reaches 6: if hist == 0, restart the fill (the all-zero state is illegal); otherwise go to VER with ver_cnt = 0.
- FSM state VER (verify):
  - Shift rx_bit into hist.
  - On a match, ver_cnt increments; when it reaches LOCK_CNT, go to CHK.
  - On a mismatch, go to ACQ with fill_cnt = 0.
  - Errors here do not touch err_cnt or err_pulse.
- FSM state CHK (locked):
  - Shift pred (not rx_bit) into hist, so an error does not propagate into the reference.
  - On a mismatch: err_pulse = 1 the next cycle, err_cnt increments (saturating at all-ones), and win_err increments.
  - win_cnt counts valid bits 0..WIN_LEN-1 and wraps to 0; win_err is zeroed on wrap.
  - When win_err reaches LOSS_THRESH: go to ACQ, zero fill_cnt, win_cnt and win_err; err_cnt is retained.
  - If the error that reaches threshold lands on the window-wrap bit, loss of lock takes priority.
- Latency: locked and err_pulse are registered and reflect the rx_valid event one clk later. err_cnt updates in the same cycle err_pulse asserts.
- clr zeroes err_cnt the next cycle and does not affect lock or the FSM. If clr and an error coincide, clr wins (err_cnt = 0) but err_pulse still asserts.
- Reset (any time, including mid-lock): state = ACQ, hist = 0, all internal counters = 0, locked = 0, err_pulse = 0, err_cnt = 0.

Optional Feature:
- Macro PRBS_CHK_BITCNT_EN.
- When defined:
  - Adds output bit_cnt (32 bits), counting valid bits checked while in CHK.
  - bit_cnt saturates at all-ones, clears on rst and clr, and updates in the same cycle as err_cnt.
  - Gives BER = err_cnt / bit_cnt.
- When undefined: no port and no counter; the rest of the behaviour is identical.

Decomposition:
- Shared package: the state encoding (ACQ/VER/CHK), the LFSR order (6), and the tap positions (5, 4).
- Both generator and checker use the same tap constants.
- Natural sub-module prbs_err_counter: saturating counter with clear, ERR_W wide, reused for err_cnt and bit_cnt.
- The FSM and history register stay in prbs_checker.

Test Plan:
- Clean lock: drive the generator stream from seed 000001 (bits 0,0,0,0,0,1,0,0,0,0,1,1,...) with rx_valid every 4th clk. Expect locked=1 one clk after valid bit #14 (6 + LOCK_CNT), then err_cnt=0 over 200 bits.
- Single error while locked: invert one bit after lock. Expect a single err_pulse, err_cnt=1, locked stays 1, and no further errors on subsequent bits.
- Loss of lock: inject 4 errors within 20 bits. Expect locked=0 one clk after the 4th error's rx_valid, err_cnt=4, then relock within 14 clean valid bits.
- Illegal pattern: drive rx_bit=0 constantly for 100 valid bits. Expect locked never asserts and err_cnt=0.
- clr/error collision: assert clr in the same cycle as an error while err_cnt=5. Expect err_cnt=0 and err_pulse=1 on the next clk.
- Reset mid-lock: pulse rst for one clk while locked with err_cnt=3. Expect locked=0 and err_cnt=0 next clk, then relock after 14 clean valid bits. With PRBS_CHK_BITCNT_EN, bit_cnt=0 after reset.

Source files
------------

// File: rtl/prbs_checker_pkg.sv
// Shared definitions for the 6-bit PRBS (x^6+x^5+1) generator/checker pair:
// checker state encoding, LFSR order, tap positions and the prediction helper.
package prbs_checker_pkg;

    typedef enum logic [1:0] {
        ST_ACQ = 2'd0,   // filling the history register
        ST_VER = 2'd1,   // verifying predictions before declaring lock
        ST_CHK = 2'd2    // locked, counting errors
    } state_t;

    localparam int PRBS_ORDER = 6;
    localparam int TAP_A      = 5;
    localparam int TAP_B      = 4;

    // Next expected bit from the last PRBS_ORDER received bits (hist[0] newest).
    function automatic logic prbs_predict(input logic [PRBS_ORDER-1:0] hist);
        return hist[TAP_A] ^ hist[TAP_B];
    endfunction

endpackage

// File: rtl/prbs_err_counter.sv
// Saturating up-counter with synchronous clear. Clear has priority over
// increment; the count holds at all-ones once reached.
module prbs_err_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_r;

    // Counter register: reset/clear to zero, otherwise saturating increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r != '1)) begin
            cnt_r <= cnt_r + ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising checker for the 6-bit PRBS stream (x^6+x^5+1, period 63).
// ACQ fills the history, VER confirms LOCK_CNT correct predictions, CHK
// counts errors and drops lock after LOSS_THRESH errors in one WIN_LEN window.
// Optional macro PRBS_CHK_BITCNT_EN adds a 32-bit count of bits checked in CHK.
module prbs_checker
    import prbs_checker_pkg::*;
#(
    parameter int LOCK_CNT    = 8,
    parameter int WIN_LEN     = 63,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic             rx_bit,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
`ifdef PRBS_CHK_BITCNT_EN
    ,
    output logic [31:0]      bit_cnt
`endif
);

    localparam int VER_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W = $clog2(WIN_LEN + 1);
    localparam int WE_W  = $clog2(LOSS_THRESH + 1);

    state_t                  state_r;
    logic [PRBS_ORDER-1:0]   hist_r;
    logic [2:0]              fill_cnt_r;
    logic [VER_W-1:0]        ver_cnt_r;
    logic [WIN_W-1:0]        win_cnt_r;
    logic [WE_W-1:0]         win_err_r;
    logic                    locked_r;
    logic                    err_pulse_r;

    logic                    pred_s;
    logic                    mismatch_s;
    logic [PRBS_ORDER-1:0]   hist_rx_s;
    logic                    chk_bit_s;
    logic                    err_inc_s;

    assign pred_s     = prbs_predict(hist_r);
    assign mismatch_s = rx_bit ^ pred_s;
    assign hist_rx_s  = {hist_r[PRBS_ORDER-2:0], rx_bit};
    assign chk_bit_s  = rx_valid && (state_r == ST_CHK);
    assign err_inc_s  = chk_bit_s && mismatch_s;

    // Lock FSM, history register, window counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_ACQ;
            hist_r      <= '0;
            fill_cnt_r  <= 3'd0;
            ver_cnt_r   <= '0;
            win_cnt_r   <= '0;
            win_err_r   <= '0;
            locked_r    <= 1'b0;
            err_pulse_r <= 1'b0;
        end else begin
            err_pulse_r <= err_inc_s;
            if (rx_valid) begin
                case (state_r)
                    ST_ACQ: begin
                        hist_r <= hist_rx_s;
                        // The sixth bit completes the fill and is judged here,
                        // so verification starts with the seventh bit.
                        if (fill_cnt_r == 3'd5) begin
                            fill_cnt_r <= 3'd0;
                            if (hist_rx_s == '0) begin
                                state_r <= ST_ACQ;
                            end else begin
                                state_r   <= ST_VER;
                                ver_cnt_r <= '0;
                            end
                        end else begin
                            fill_cnt_r <= fill_cnt_r + 3'd1;
                        end
                    end
                    ST_VER: begin
                        hist_r <= hist_rx_s;
                        if (mismatch_s) begin
                            state_r    <= ST_ACQ;
                            fill_cnt_r <= 3'd0;
                        end else if (ver_cnt_r == VER_W'(LOCK_CNT - 1)) begin
                            state_r   <= ST_CHK;
                            locked_r  <= 1'b1;
                            win_cnt_r <= '0;
                            win_err_r <= '0;
                        end else begin
                            ver_cnt_r <= ver_cnt_r + VER_W'(1);
                        end
                    end
                    ST_CHK: begin
                        // Feed back the prediction so a bad bit never pollutes the reference.
                        hist_r <= {hist_r[PRBS_ORDER-2:0], pred_s};
                        if (mismatch_s && (win_err_r == WE_W'(LOSS_THRESH - 1))) begin
                            state_r    <= ST_ACQ;
                            locked_r   <= 1'b0;
                            fill_cnt_r <= 3'd0;
                            win_cnt_r  <= '0;
                            win_err_r  <= '0;
                        end else if (win_cnt_r == WIN_W'(WIN_LEN - 1)) begin
                            win_cnt_r <= '0;
                            win_err_r <= '0;
                        end else begin
                            win_cnt_r <= win_cnt_r + WIN_W'(1);
                            win_err_r <= win_err_r + WE_W'(mismatch_s);
                        end
                    end
                    default: begin
                        state_r    <= ST_ACQ;
                        locked_r   <= 1'b0;
                        fill_cnt_r <= 3'd0;
                    end
                endcase
            end
        end
    end

    prbs_err_counter #(.W(ERR_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (err_inc_s),
        .cnt (err_cnt)
    );

`ifdef PRBS_CHK_BITCNT_EN
    prbs_err_counter #(.W(32)) u_bit_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (chk_bit_s),
        .cnt (bit_cnt)
    );
`endif

    assign locked    = locked_r;
    assign err_pulse = err_pulse_r;

endmodule
